// File: rtl/cesus_pkg.sv
// Shared op-codes, FSM states and size helpers for the census/Hamming engine.
package cesus_pkg;

    localparam logic [3:0] OP_CLEAR  = 4'd0;
    localparam logic [3:0] OP_PUSH   = 4'd1;
    localparam logic [3:0] OP_CREF   = 4'd2;
    localparam logic [3:0] OP_CCUR   = 4'd3;
    localparam logic [3:0] OP_SEARCH = 4'd4;
    localparam logic [3:0] OP_RDCUR  = 4'd5;
    localparam logic [3:0] OP_SETCNT = 4'd6;
    localparam logic [3:0] OP_GETCNT = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic int f_n(input int win);
        return win * win;
    endfunction

    function automatic int f_cb(input int win);
        return win * win - 1;
    endfunction

    function automatic int f_p(input int pw);
        return 32 / pw;
    endfunction

endpackage

// File: rtl/cesus_popcnt.sv
// Combinational population count of a W-bit vector.
module cesus_popcnt #(
    parameter int W  = 8,
    parameter int OW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_vec,
    output logic [OW-1:0] o_cnt
);

    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < W; i++) o_cnt = o_cnt + OW'(i_vec[i]);
    end

endmodule

// File: rtl/cesus_ms.sv
// Multicycle census/Hamming custom instruction: window, census codecs,
// reference ring and a sequential winner-take-all disparity search.
module cesus_ms
    import cesus_pkg::*;
#(
    parameter int WIN   = 11,
    parameter int PW    = 8,
    parameter int NDISP = 16
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iClk_en,
    input  logic        iStart,
    input  logic [3:0]  iOp,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    output logic        oDone,
    output logic [31:0] oRes
);

    localparam int N  = f_n(WIN);
    localparam int CB = f_cb(WIN);
    localparam int C  = N / 2;
    localparam int WW = N * PW;
    localparam int CW = $clog2(CB + 1);
    localparam int IW = $clog2(NDISP);
    localparam int SW = $clog2(NDISP + 1);

    state_t                      r_state, w_nstate;
    logic                        w_start, w_scan_end;
    logic [WW-1:0]               r_win;
    logic [NDISP-1:0][CB-1:0]    r_ring;
    logic [NDISP-1:0]            r_vld;
    logic [CB-1:0]               r_cur;
    logic [31:0]                 r_cnt, r_res, r_a;
    logic [3:0]                  r_op;
    logic                        r_done;
    logic [SW-1:0]               r_step;
    logic [IW-1:0]               w_fidx, r_cost_d, r_best_d, w_nb_d;
    logic [CW-1:0]               r_cost, r_best_cost, w_nb_cost, w_cost, w_census_cnt;
    logic                        r_cost_ok, r_found, w_nb_found, w_take;
    logic [CB-1:0]               w_census;
    logic [255:0]                w_cur_pad;
    logic                        w_unused_b;

    assign w_unused_b = ^iB;
    assign oDone      = r_done;
    assign oRes       = r_res;
    assign w_cur_pad  = 256'(r_cur);

    for (genvar j = 0; j < CB; j++) begin : g_census
        localparam int K = (j < C) ? j : j + 1;
        assign w_census[j] = r_win[K*PW +: PW] < r_win[C*PW +: PW];
    end

    cesus_popcnt #(.W(CB), .OW(CW)) u_pc_census (.i_vec(w_census), .o_cnt(w_census_cnt));

    // Cost of the fetched ring entry is registered before the compare so the
    // XOR/popcount path and the min-compare sit in separate cycles.
    assign w_fidx = (r_step < SW'(NDISP)) ? IW'(r_step) : '0;
    cesus_popcnt #(.W(CB), .OW(CW)) u_pc_cost (.i_vec(r_cur ^ r_ring[w_fidx]), .o_cnt(w_cost));

    assign w_take = (r_step != '0) && r_cost_ok && (!r_found || (r_cost < r_best_cost));

    always_comb begin
        w_nb_found = r_found;
        w_nb_cost  = r_best_cost;
        w_nb_d     = r_best_d;
        if (w_take) begin
            w_nb_found = 1'b1;
            w_nb_cost  = r_cost;
            w_nb_d     = r_cost_d;
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset)       r_state <= S_IDLE;
        else if (iClk_en) r_state <= w_nstate;
    end

    always_comb begin
        w_nstate   = r_state;
        w_start    = 1'b0;
        w_scan_end = 1'b0;
        case (r_state)
            S_IDLE: if (iStart) begin
                w_start  = 1'b1;
                w_nstate = (iOp == OP_SEARCH) ? S_SCAN : S_EXEC;
            end
            S_EXEC: w_nstate = S_DONE;
            S_SCAN: if (r_step == SW'(NDISP)) begin
                w_scan_end = 1'b1;
                w_nstate   = S_DONE;
            end
            S_DONE: w_nstate = S_IDLE;
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_win       <= '1;
            r_ring      <= '0;
            r_vld       <= '0;
            r_cur       <= '0;
            r_cnt       <= '0;
            r_res       <= '0;
            r_a         <= '0;
            r_op        <= '0;
            r_done      <= 1'b0;
            r_step      <= '0;
            r_cost      <= '0;
            r_cost_ok   <= 1'b0;
            r_cost_d    <= '0;
            r_best_cost <= '0;
            r_best_d    <= '0;
            r_found     <= 1'b0;
        end else if (iClk_en) begin
            r_done <= (r_state == S_DONE);
            if (w_start) begin
                r_op    <= iOp;
                r_a     <= iA;
                r_step  <= '0;
                r_found <= 1'b0;
                if (iOp != OP_SETCNT) r_cnt <= r_cnt + 32'd1;
            end
            if (r_state == S_EXEC) begin
                case (r_op)
                    OP_CLEAR: begin
                        r_win <= '1;
                        r_vld <= '0;
                        r_res <= '0;
                    end
                    OP_PUSH: begin
                        r_win <= (r_win << 32) | WW'(r_a);
                        r_res <= '0;
                    end
                    OP_CREF: begin
                        r_ring <= {r_ring[NDISP-2:0], w_census};
                        r_vld  <= {r_vld[NDISP-2:0], 1'b1};
                        r_res  <= 32'(w_census_cnt);
                    end
                    OP_CCUR: begin
                        r_cur <= w_census;
                        r_res <= 32'(w_census_cnt);
                    end
                    OP_RDCUR:  r_res <= w_cur_pad[{r_a[2:0], 5'b0} +: 32];
                    OP_SETCNT: begin
                        r_cnt <= r_a;
                        r_res <= r_a;
                    end
                    // The counter already took this op's increment at start.
                    OP_GETCNT: r_res <= r_cnt - 32'd1;
                    default:   r_res <= '0;
                endcase
            end
            if (r_state == S_SCAN) begin
                if (r_step < SW'(NDISP)) begin
                    r_cost    <= w_cost;
                    r_cost_ok <= r_vld[w_fidx];
                    r_cost_d  <= w_fidx;
                end
                r_found     <= w_nb_found;
                r_best_cost <= w_nb_cost;
                r_best_d    <= w_nb_d;
                if (w_scan_end)
                    r_res <= w_nb_found ? {16'(w_nb_cost), 16'(w_nb_d)} : 32'hFFFF_FFFF;
                else
                    r_step <= r_step + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cesus_ms.sv
// Randomised self-checking bench for cesus_ms against a pixel-array model.
module tb_cesus_ms;

    localparam int WIN = 3;
    localparam int PW  = 8;
    localparam int ND  = 4;
    localparam int N   = 9;
    localparam int CB  = 8;
    localparam int P   = 4;
    localparam int C   = 4;

    logic        iClk = 1'b0;
    logic        iReset, iClk_en, iStart;
    logic [3:0]  iOp;
    logic [31:0] iA, iB, oRes;
    logic        oDone;

    int n_err = 0;
    int n_chk = 0;

    logic [7:0]    m_pix  [N];
    logic [CB-1:0] m_ring [ND];
    logic          m_vld  [ND];
    logic [CB-1:0] m_cur;
    logic [31:0]   m_cnt;

    always #5 iClk = ~iClk;

    cesus_ms #(.WIN(WIN), .PW(PW), .NDISP(ND)) dut (
        .iClk(iClk), .iReset(iReset), .iClk_en(iClk_en), .iStart(iStart),
        .iOp(iOp), .iA(iA), .iB(iB), .oDone(oDone), .oRes(oRes)
    );

    function automatic void m_reset();
        for (int k = 0; k < N; k++) m_pix[k] = 8'hFF;
        for (int d = 0; d < ND; d++) begin m_ring[d] = '0; m_vld[d] = 1'b0; end
        m_cur = '0;
        m_cnt = '0;
    endfunction

    function automatic logic [CB-1:0] m_census();
        logic [CB-1:0] c;
        for (int j = 0; j < CB; j++) c[j] = m_pix[(j < C) ? j : j + 1] < m_pix[C];
        return c;
    endfunction

    function automatic logic [31:0] model_op(input logic [3:0] op, input logic [31:0] a);
        logic [31:0] r;
        logic [CB-1:0] c;
        int best, bc, cost;
        r = 32'h0;
        case (op)
            4'd0: begin
                for (int k = 0; k < N; k++) m_pix[k] = 8'hFF;
                for (int d = 0; d < ND; d++) m_vld[d] = 1'b0;
            end
            4'd1: begin
                for (int k = N - 1; k >= P; k--) m_pix[k] = m_pix[k-P];
                for (int k = 0; k < P; k++) m_pix[k] = a[8*k +: 8];
            end
            4'd2: begin
                c = m_census();
                for (int d = ND - 1; d > 0; d--) begin m_ring[d] = m_ring[d-1]; m_vld[d] = m_vld[d-1]; end
                m_ring[0] = c;
                m_vld[0]  = 1'b1;
                r = 32'($countones(c));
            end
            4'd3: begin
                m_cur = m_census();
                r = 32'($countones(m_cur));
            end
            4'd4: begin
                best = -1;
                bc   = 0;
                for (int d = 0; d < ND; d++) if (m_vld[d]) begin
                    cost = $countones(m_cur ^ m_ring[d]);
                    if (best < 0 || cost < bc) begin best = d; bc = cost; end
                end
                r = (best < 0) ? 32'hFFFF_FFFF : {16'(bc), 16'(best)};
            end
            4'd5: r = (a[2:0] == 3'd0) ? 32'(m_cur) : 32'h0;
            4'd6: begin m_cnt = a; r = a; end
            4'd7: r = m_cnt;
            default: r = 32'h0;
        endcase
        if (op != 4'd6) m_cnt = m_cnt + 32'd1;
        return r;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          output logic [31:0] res, output logic [31:0] e, output int lat);
        @(negedge iClk);
        iStart = 1'b1; iOp = op; iA = a; iB = $urandom;
        @(posedge iClk); #1;
        iStart = 1'b0;
        e   = model_op(op, a);
        lat = -1;
        res = 32'h0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge iClk); #1;
            if (oDone) begin lat = i; res = oRes; break; end
        end
    endtask

    task automatic load_code(input logic [CB-1:0] code);
        logic [7:0] p [N];
        logic [31:0] r, e;
        int l;
        p[C] = 8'h80;
        for (int j = 0; j < CB; j++) p[(j < C) ? j : j + 1] = code[j] ? 8'h00 : 8'hFF;
        run_op(4'd1, {24'h0, p[8]}, r, e, l);
        run_op(4'd1, {p[7], p[6], p[5], p[4]}, r, e, l);
        run_op(4'd1, {p[3], p[2], p[1], p[0]}, r, e, l);
    endtask

    task automatic test_reset();
        logic [31:0] r, e;
        int l;
        n_chk++;
        if (oDone !== 1'b0 || oRes !== 32'h0) begin
            n_err++; $display("FAIL reset_state: done=%b res=%h required done=0 res=0", oDone, oRes);
        end
        run_op(4'd4, 32'h0, r, e, l);
        n_chk++;
        if (r !== 32'hFFFF_FFFF || r !== e) begin
            n_err++; $display("FAIL reset_search: got %h required FFFFFFFF", r);
        end
        n_chk++;
        if (l !== ND + 2) begin
            n_err++; $display("FAIL reset_search_lat: got %0d required %0d", l, ND + 2);
        end
        @(posedge iClk); #1;
        n_chk++;
        if (oDone !== 1'b0) begin
            n_err++; $display("FAIL done_one_pulse: done=%b required 0", oDone);
        end
        run_op(4'd7, 32'h0, r, e, l);
        n_chk++;
        if (r !== e) begin
            n_err++; $display("FAIL reset_getcnt: got %h required %h", r, e);
        end
    endtask

    task automatic test_census();
        logic [31:0] r, e;
        int l;
        run_op(4'd0, 32'h0, r, e, l);
        run_op(4'd1, 32'h04030201, r, e, l);
        run_op(4'd1, 32'h08070605, r, e, l);
        run_op(4'd1, 32'h00000009, r, e, l);
        n_chk++;
        if (r !== 32'h0 || l !== 2) begin
            n_err++; $display("FAIL push: res=%h lat=%0d required res=0 lat=2", r, l);
        end
        run_op(4'd3, 32'h0, r, e, l);
        n_chk++;
        if (r !== e) begin
            n_err++; $display("FAIL census_cur: got %h required %h", r, e);
        end
        run_op(4'd5, 32'h0, r, e, l);
        n_chk++;
        if (r !== e) begin
            n_err++; $display("FAIL read_cur0: got %h required %h", r, e);
        end
        run_op(4'd5, 32'h1, r, e, l);
        n_chk++;
        if (r !== 32'h0) begin
            n_err++; $display("FAIL read_cur1: got %h required 0", r);
        end
    endtask

    task automatic test_tiebreak();
        logic [31:0] r, e;
        logic [CB-1:0] seq [5];
        int l;
        seq = '{8'hFF, 8'h0F, 8'hF0, 8'h0F, 8'hF0};
        run_op(4'd0, 32'h0, r, e, l);
        for (int i = 0; i < 4; i++) begin load_code(seq[i]); run_op(4'd2, 32'h0, r, e, l); end
        load_code(seq[4]);
        run_op(4'd3, 32'h0, r, e, l);
        run_op(4'd4, 32'h0, r, e, l);
        n_chk++;
        if (r !== 32'h0000_0001 || r !== e) begin
            n_err++; $display("FAIL wta_basic: got %h required 00000001", r);
        end
        seq = '{8'h3C, 8'h00, 8'h3C, 8'hC3, 8'h3C};
        run_op(4'd0, 32'h0, r, e, l);
        for (int i = 0; i < 4; i++) begin load_code(seq[i]); run_op(4'd2, 32'h0, r, e, l); end
        load_code(seq[4]);
        run_op(4'd3, 32'h0, r, e, l);
        run_op(4'd4, 32'h0, r, e, l);
        n_chk++;
        if (r !== 32'h0000_0001 || r !== e) begin
            n_err++; $display("FAIL wta_tie: got %h required 00000001", r);
        end
    endtask

    task automatic test_partial();
        logic [31:0] r, e;
        int l;
        run_op(4'd0, 32'h0, r, e, l);
        load_code(8'hA5);
        run_op(4'd2, 32'h0, r, e, l);
        run_op(4'd3, 32'h0, r, e, l);
        run_op(4'd4, 32'h0, r, e, l);
        n_chk++;
        if (r !== 32'h0 || r !== e) begin
            n_err++; $display("FAIL partial_ring: got %h required 00000000", r);
        end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        int l;
        @(negedge iClk);
        iStart = 1'b1; iOp = 4'd4; iA = $urandom;
        @(posedge iClk); #1;
        iStart = 1'b0;
        e = model_op(4'd4, iA);
        l = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge iClk); #1;
            if (i == 2) iClk_en = 1'b0;
            if (i == 7) iClk_en = 1'b1;
            if (oDone) begin l = i; break; end
        end
        iClk_en = 1'b1;
        n_chk++;
        if (l !== ND + 7) begin
            n_err++; $display("FAIL stall_lat: got %0d required %0d", l, ND + 7);
        end
        n_chk++;
        if (oRes !== e) begin
            n_err++; $display("FAIL stall_res: got %h required %h", oRes, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r, e;
        int l;
        logic seen;
        @(negedge iClk);
        iStart = 1'b1; iOp = 4'd4;
        @(posedge iClk); #1;
        iStart = 1'b0;
        @(posedge iClk); #1;
        iReset = 1'b1;
        @(posedge iClk); #1;
        iReset = 1'b0;
        m_reset();
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin @(posedge iClk); #1; if (oDone) seen = 1'b1; end
        n_chk++;
        if (seen !== 1'b0 || oRes !== 32'h0) begin
            n_err++; $display("FAIL reset_mid: done_seen=%b res=%h required 0/0", seen, oRes);
        end
        run_op(4'd4, 32'h0, r, e, l);
        n_chk++;
        if (r !== 32'hFFFF_FFFF || r !== e) begin
            n_err++; $display("FAIL reset_mid_ring: got %h required FFFFFFFF", r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, e;
        int l;
        run_op(4'd6, 32'd100, r, e, l);
        n_chk++;
        if (r !== 32'd100) begin
            n_err++; $display("FAIL set_cnt: got %h required 100", r);
        end
        run_op(4'd1, $urandom, r, e, l);
        run_op(4'd3, 32'h0, r, e, l);
        @(negedge iClk);
        iStart = 1'b1; iOp = 4'd5; iA = 32'h0;
        @(posedge iClk); #1;
        e = model_op(4'd5, 32'h0);
        iOp = 4'd6;
        @(posedge iClk); #1;
        iStart = 1'b0;
        l = -1;
        for (int i = 2; i <= 100; i++) begin
            @(posedge iClk); #1;
            if (oDone) begin l = i; break; end
        end
        n_chk++;
        if (l !== 2 || oRes !== e) begin
            n_err++; $display("FAIL busy_op: lat=%0d res=%h required lat=2 res=%h", l, oRes, e);
        end
        run_op(4'd7, 32'h0, r, e, l);
        n_chk++;
        if (r !== e || r !== 32'd103) begin
            n_err++; $display("FAIL get_cnt: got %0d required %0d", r, e);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, e, a;
        logic [3:0] op;
        int l;
        for (int it = 0; it < 80; it++) begin
            a = $urandom;
            case ($urandom_range(0, 10))
                0, 1:    op = 4'd1;
                2, 3:    op = 4'd2;
                4:       op = 4'd3;
                5, 6:    op = 4'd4;
                7:       op = 4'd5;
                8:       op = 4'($urandom_range(6, 7));
                9:       op = 4'($urandom_range(8, 15));
                default: op = 4'd0;
            endcase
            run_op(op, a, r, e, l);
            n_chk++;
            if (r !== e) begin
                n_err++; $display("FAIL rand_res op=%0d: got %h required %h", op, r, e);
            end
            n_chk++;
            if (l !== ((op == 4'd4) ? ND + 2 : 2)) begin
                n_err++; $display("FAIL rand_lat op=%0d: got %0d required %0d", op, l, (op == 4'd4) ? ND + 2 : 2);
            end
        end
    endtask

    initial begin
        iReset = 1'b1; iClk_en = 1'b1; iStart = 1'b0; iOp = 4'd0; iA = 32'h0; iB = 32'h0;
        m_reset();
        repeat (3) @(posedge iClk);
        #1 iReset = 1'b0;
        test_reset();
        test_census();
        test_tiebreak();
        test_partial();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
